// File: rtl/dm_pkg.sv
// Shared defaults and helpers for the dm_data_memory block.
package dm_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 256;

    // Width of an index that reaches every implemented word (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dm_data_memory_if.sv
// Single-port word bus of the data memory: shared address, write data/enable, read data.
interface dm_data_memory_if
    import dm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] direccion;
    logic [DATA_W-1:0] dataWrite;
    logic              memWr;
    logic [DATA_W-1:0] dataRead;

    modport master (
        output direccion,
        output dataWrite,
        output memWr,
        input  dataRead
    );

    modport slave (
        input  direccion,
        input  dataWrite,
        input  memWr,
        output dataRead
    );

endinterface

// File: rtl/dm_valid_bits.sv
// One valid flag per memory word: asynchronous clear, synchronous set, combinational lookup.
module dm_valid_bits
    import dm_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] look_idx,
    output logic             look_valid
);

    logic [DEPTH-1:0] valid_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                end else if (set_en && (set_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Caller guarantees look_idx < DEPTH before trusting the result.
    assign look_valid = valid_reg[look_idx];

endmodule

// File: rtl/dm_data_memory.sv
// Word-addressed data memory: synchronous write, zero-latency read, words read as zero until written.
module dm_data_memory
    import dm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_data_memory_if.slave   bus
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              wr_en;
    logic              word_valid;

    // Extra bit keeps the bound correct when DEPTH equals 2**ADDR_W.
    assign in_range = ({1'b0, bus.direccion} < (ADDR_W + 1)'(DEPTH));
    assign idx      = bus.direccion[IDX_W-1:0];
    assign wr_en    = bus.memWr && in_range && rst_n;

    // No reset on the array so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= bus.dataWrite;
        end
    end

    dm_valid_bits #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_valid_bits (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (wr_en),
        .set_idx    (idx),
        .look_idx   (idx),
        .look_valid (word_valid)
    );

    assign bus.dataRead = (in_range && word_valid) ? mem[idx] : '0;

endmodule

// File: tb/tb_dm_data_memory.sv
// Scoreboard bench for dm_data_memory: directed scenarios then random traffic against an array model.
module tb_dm_data_memory;
    import dm_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int DP = DEPTH_DEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dm_data_memory_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_data_memory #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model: plain word array plus written flags.
    logic [DW-1:0] ref_mem   [DP];
    bit            ref_valid [DP];

    function automatic logic [DW-1:0] ref_read(input int a);
        if (a < DP && ref_valid[a]) return ref_mem[a];
        return '0;
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < DP; i++) ref_valid[i] = 1'b0;
    endfunction

    logic [DW-1:0] exp_q  [$];
    int            addr_q [$];
    string         name_q [$];

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] mon_exp;
    int            mon_addr;
    string         mon_name;

    // Monitor: every expectation is checked at the falling edge of the cycle it was issued in.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_addr = addr_q.pop_front();
            mon_name = name_q.pop_front();
            compared++;
            if (bus.dataRead !== mon_exp) begin
                mismatched++;
                $display("FAIL %s addr=%03h got=%016h exp=%016h", mon_name, mon_addr, bus.dataRead, mon_exp);
            end else begin
                $display("ok   %s addr=%03h data=%016h", mon_name, mon_addr, bus.dataRead);
            end
        end
    end

    // One bus cycle, entered just after a rising edge; the check sees the pre-edge read.
    task automatic cyc(input int a, input logic [DW-1:0] wd, input bit wr, input string nm);
        bus.direccion = AW'(a);
        bus.dataWrite = wd;
        bus.memWr     = wr;
        exp_q.push_back(ref_read(a));
        addr_q.push_back(a);
        name_q.push_back(nm);
        @(posedge clk);
        if (rst_n && wr && a < DP) begin
            ref_mem[a]   = wd;
            ref_valid[a] = 1'b1;
        end
        #1;
    endtask

    // Reset pulse inside one cycle, released before the next rising edge.
    task automatic pulse_reset(input int a);
        bus.direccion = AW'(a);
        bus.memWr     = 1'b0;
        rst_n         = 1'b0;
        ref_clear();
        exp_q.push_back('0);
        addr_q.push_back(a);
        name_q.push_back("rst_pulse");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired compared=%0d", compared);
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int sel;
        logic [DW-1:0] d;

        rst_n         = 1'b0;
        bus.direccion = '0;
        bus.dataWrite = '0;
        bus.memWr     = 1'b0;
        ref_clear();
        repeat (2) @(posedge clk);
        #1;

        cyc(0,      '0,     1'b0, "rst_a000");
        cyc(10,     '0,     1'b0, "rst_a00a");
        cyc(DP - 1, 64'h99, 1'b1, "rst_top_wr");
        cyc(DP - 1, '0,     1'b0, "rst_blocked");

        rst_n = 1'b1;
        cyc(10, 64'h14, 1'b1, "wr_a00a");
        for (int i = 0; i < 10; i++) cyc(10, '0, 1'b0, "hold_a00a");

        cyc(1, 64'hDEADBEEFCAFEF00D, 1'b1, "wr_a001");
        cyc(2, 64'h1,                1'b1, "wr_a002");
        cyc(1, '0, 1'b0, "rd_a001");
        cyc(2, '0, 1'b0, "rd_a002");
        cyc(3, '0, 1'b0, "rd_a003");

        cyc(10, 64'hFF, 1'b1, "rdw_before");
        cyc(10, '0,     1'b0, "rdw_after");

        cyc(0,  64'h1234, 1'b1, "wr_a000");
        cyc(DP, 64'h55,   1'b1, "wr_oob");
        cyc(DP, '0,       1'b0, "rd_oob");
        cyc(0,  '0,       1'b0, "rd_a000_kept");

        cyc(10, 64'h14, 1'b1, "wr_a00a_again");
        cyc(10, '0,     1'b0, "rd_pre_rst");
        pulse_reset(10);
        cyc(10, '0,    1'b0, "rd_post_rst");
        cyc(1,  '0,    1'b0, "rd_a001_cleared");
        cyc(10, 64'h7, 1'b1, "wr_7");
        cyc(10, '0,    1'b0, "rd_7");

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 2) begin
                pulse_reset($urandom_range(0, 31));
            end else begin
                if (sel < 80) a = $urandom_range(0, 31);
                else if (sel < 90) a = DP + $urandom_range(0, 31);
                else a = (1 << AW) - 1 - $urandom_range(0, 31);
                d = {$urandom, $urandom};
                cyc(a, d, 1'($urandom_range(0, 1)), "rnd");
            end
        end

        bus.memWr = 1'b0;
        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dm_data_memory.md
DM_DATA_MEMORY -- requirements
Module: dm_data_memory

Interface
REQ-001 Parameter ADDR_W, default 12: address width in bits.
REQ-002 Parameter DATA_W, default 64: data word width in bits.
REQ-003 Parameter DEPTH, default 256, legal range 1..2**ADDR_W: number of implemented words.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  clock; all writes occur on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 direccion  input  ADDR_W  word address, shared by read and write; one address per 64-bit word, no byte addressing.
REQ-008 dataWrite  input  DATA_W  write data.
REQ-009 memWr  input  1  write enable, active high.
REQ-010 dataRead  output  DATA_W  read data.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_W bits, each with one valid bit.
REQ-012 Write: on a rising clk edge with memWr=1, rst_n=1 and direccion<DEPTH, mem[direccion] SHALL take dataWrite and its valid bit SHALL be set.
REQ-013 A write with direccion>=DEPTH SHALL be ignored, with no aliasing or wrap-around onto lower addresses.
REQ-014 Read SHALL be combinational with zero latency: dataRead = mem[direccion] when direccion<DEPTH and the word is valid, otherwise all zeros.
REQ-015 The read path SHALL be independent of memWr; reads are always enabled.
REQ-016 Read-during-write to the same address: before the edge, dataRead SHALL show the old content (zero if not yet valid); after the edge, it SHALL show the new data, with no bypass of dataWrite.
REQ-017 Consecutive writes to the same address SHALL leave the last written value.
REQ-018 memWr=0 SHALL leave storage and valid bits unchanged.
REQ-019 X or Z on direccion SHALL NOT corrupt any word when memWr=0.

Reset
REQ-020 While rst_n=0, all valid bits SHALL clear immediately (asynchronously), so dataRead reads 0 for every address.
REQ-021 Data words SHALL NOT be reset; only the valid bits are reset.
REQ-022 Writes SHALL be blocked while rst_n=0.
REQ-023 On the first rising edge after rst_n deasserts, a write with memWr=1 SHALL take effect.
REQ-024 Reset asserted between writes SHALL make all previously written words read 0 until they are rewritten.

Structure
REQ-025 ADDR_W and DATA_W defaults and a DEPTH default constant SHALL be placed in the shared package dm_pkg.
REQ-026 One sub-module, dm_valid_bits, SHALL hold the DEPTH-bit valid vector with its asynchronous clear, a set port and a combinational lookup.
REQ-027 The data array SHALL be inferable as distributed RAM: synchronous write, asynchronous read, and no reset on the array.

Verification
REQ-028 Reset, then read addresses 0x000, 0x00A and DEPTH-1 -> dataRead=0 for each.
REQ-029 Set direccion=0x00A, dataWrite=0x14, memWr=1, one edge -> dataRead=0x0000000000000014 immediately after the edge; with memWr=0 the value is held over 10 cycles.
REQ-030 Write 0xDEADBEEFCAFEF00D to 0x001 and 0x1 to 0x002 -> reading 0x001 then 0x002 returns the respective values; address 0x003 reads 0.
REQ-031 Hold direccion=0x00A with 0x14 stored, present dataWrite=0xFF with memWr=1 -> dataRead=0x14 before the edge and 0xFF after it.
REQ-032 Write 0x55 to address DEPTH (0x100) -> dataRead=0 at 0x100 and address 0x000 is unchanged.
REQ-033 Write 0x14 to 0x00A, pulse rst_n low mid-cycle -> dataRead drops to 0 without a clock edge; a later write of 0x7 to 0x00A reads back 0x7.
